// File: rtl/aud_pkg.sv
// Shared audio-path types and defaults.
// Used by the recorder and the future player.
package aud_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 20;
  localparam int I2S_DELAY = 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LRC,
    SHIFT,
    WRITE,
    PAUSED
  } state_t;

endpackage

// File: rtl/aud_recorder_if.sv
// Control, codec-serial and SRAM-write signals of the recorder.
// The recorder takes the slave side.
interface aud_recorder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);

  logic              i_init_done;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic              i_lrc;
  logic              i_adcdat;
  logic [DATA_W-1:0] o_data;
  logic [ADDR_W-1:0] o_address;
  logic              o_wr_en;
  logic [ADDR_W:0]   o_sample_cnt;
  logic              o_busy;
  logic              o_full;

  modport master (
    output i_init_done, i_start, i_pause,
    output i_stop, i_lrc, i_adcdat,
    input  o_data, o_address, o_wr_en,
    input  o_sample_cnt, o_busy, o_full
  );

  modport slave (
    input  i_init_done, i_start, i_pause,
    input  i_stop, i_lrc, i_adcdat,
    output o_data, o_address, o_wr_en,
    output o_sample_cnt, o_busy, o_full
  );

endinterface

// File: rtl/aud_recorder.sv
// Left-channel I2S deserialiser with start/pause/stop control
// and a sequential SRAM write address.
module aud_recorder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input logic           i_clk,
  input logic           i_rst,
  aud_recorder_if.slave bus
);

  import aud_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + I2S_DELAY);

  state_t state;
  state_t next;

  logic              lrc_q;
  logic              fall;
  logic              last_bit;
  logic              pend;
  logic              full;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;

  assign fall     = lrc_q & ~bus.i_lrc;
  assign last_bit = cnt == CNT_W'(DATA_W - 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    if (bus.i_stop) begin
      next = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (bus.i_start && bus.i_init_done)
            next = WAIT_LRC;
        WAIT_LRC:
          if (bus.i_pause) next = PAUSED;
          else if (fall)   next = SHIFT;
        SHIFT:
          if (last_bit) next = WRITE;
        WRITE:
          if (addr == MAX_ADDR)
            next = IDLE;
          else if (pend || bus.i_pause)
            next = PAUSED;
          else
            next = WAIT_LRC;
        PAUSED:
          if (bus.i_start) next = WAIT_LRC;
        default:
          next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lrc_q <= 1'b1;
      shreg <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      addr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      lrc_q <= bus.i_lrc;

      if (state == SHIFT) begin
        shreg <= {shreg[DATA_W-2:0], bus.i_adcdat};
        cnt   <= cnt + 1'b1;
      end else if (state == WAIT_LRC && fall) begin
        cnt <= '0;
      end

      // Pause only latches while a sample is in flight.
      if (next != SHIFT && next != WRITE)
        pend <= 1'b0;
      else if (bus.i_pause)
        pend <= 1'b1;

      if (state == IDLE && next == WAIT_LRC) begin
        addr  <= '0;
        count <= '0;
        full  <= 1'b0;
      end

      if (state == WRITE) begin
        count <= count + 1'b1;
        if (!bus.i_stop) begin
          if (addr == MAX_ADDR) full <= 1'b1;
          else                  addr <= addr + 1'b1;
        end
      end
    end
  end

  assign bus.o_data       = shreg;
  assign bus.o_address    = addr;
  assign bus.o_wr_en      = state == WRITE;
  assign bus.o_sample_cnt = count;
  assign bus.o_busy       = state != IDLE;
  assign bus.o_full       = full;

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder, built with MAX_ADDR=3
// so memory exhaustion is reachable.
module tb_aud_recorder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  aud_recorder_if #(.DATA_W(16), .ADDR_W(20)) bus ();

  aud_recorder #(
    .DATA_W(16),
    .ADDR_W(20),
    .MAX_ADDR(20'd3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [35:0] wr_q[$];
  logic        pulse_busy;
  logic [59:0] rst_snap;

  always @(negedge clk)
    if (bus.o_wr_en === 1'b1)
      wr_q.push_back({bus.o_address, bus.o_data});

  function automatic logic [35:0] last_wr();
    if (wr_q.size() == 0) return '1;
    return wr_q[wr_q.size()-1];
  endfunction

  task automatic step(input logic lrc, dat,
                      input logic start, pause, stop);
    @(negedge clk);
    bus.i_lrc    = lrc;
    bus.i_adcdat = dat;
    bus.i_start  = start;
    bus.i_pause  = pause;
    bus.i_stop   = stop;
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_pulse();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic stop_pulse();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
  endtask

  // 64-BCLK I2S frame; data is delayed one BCLK after each LRC edge.
  task automatic frame(input logic [15:0] l, r,
                       input int pause_at, stop_at, rst_at);
    for (int i = 0; i < 64; i++) begin
      int idx;
      logic [15:0] w;
      logic d;
      idx = i % 32;
      w = (i < 32) ? l : r;
      d = (idx >= 1 && idx <= 16) ? w[16-idx] : 1'b0;
      step(i >= 32, d, 1'b0, i == pause_at, i == stop_at);
      if (stop_at >= 0 && i == stop_at + 1)
        pulse_busy = bus.o_busy;
      if (rst_at >= 0 && i == rst_at) begin
        #2 rst = 1'b1;
        #1 rst_snap = {bus.o_data, bus.o_address, bus.o_wr_en,
                       bus.o_sample_cnt, bus.o_busy, bus.o_full};
      end
      if (rst_at >= 0 && i == rst_at + 3)
        rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [59:0] got;
    bus.i_init_done = 1'b1;
    bus.i_start = 1'b0;
    bus.i_pause = 1'b0;
    bus.i_stop = 1'b0;
    bus.i_lrc = 1'b1;
    bus.i_adcdat = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.o_data, bus.o_address, bus.o_wr_en,
           bus.o_sample_cnt, bus.o_busy, bus.o_full};
    vectors++;
    if (got !== 60'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_step();
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy %b want 0", bus.o_busy);
    end
  endtask

  task automatic test_init_gate();
    bus.i_init_done = 1'b0;
    start_pulse();
    idle_step();
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL init_low_start: busy %b want 0", bus.o_busy);
    end
    bus.i_init_done = 1'b1;
    start_pulse();
    idle_step();
    vectors++;
    if (bus.o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL init_high_start: busy %b want 1", bus.o_busy);
    end
    stop_pulse();
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_stop: busy %b want 0", bus.o_busy);
    end
  endtask

  task automatic test_basic();
    wr_q.delete();
    start_pulse();
    frame(16'hA5C3, 16'hFFFF, -1, -1, -1);
    vectors++;
    if (wr_q.size() !== 1) begin
      miscompares++;
      $display("FAIL basic_count1: writes %0d want 1", wr_q.size());
    end
    vectors++;
    if (last_wr() !== {20'd0, 16'hA5C3}) begin
      miscompares++;
      $display("FAIL basic_wr0: got %h want %h",
               last_wr(), {20'd0, 16'hA5C3});
    end
    vectors++;
    if (bus.o_sample_cnt !== 21'd1) begin
      miscompares++;
      $display("FAIL basic_cnt1: got %0d want 1", bus.o_sample_cnt);
    end
    frame(16'h5A3C, 16'hFFFF, -1, -1, -1);
    vectors++;
    if (last_wr() !== {20'd1, 16'h5A3C} || wr_q.size() !== 2) begin
      miscompares++;
      $display("FAIL basic_wr1: got %h n=%0d want %h n=2",
               last_wr(), wr_q.size(), {20'd1, 16'h5A3C});
    end
    vectors++;
    if (bus.o_sample_cnt !== 21'd2) begin
      miscompares++;
      $display("FAIL basic_cnt2: got %0d want 2", bus.o_sample_cnt);
    end
    stop_pulse();
  endtask

  task automatic test_pause();
    wr_q.delete();
    start_pulse();
    frame(16'h1234, 16'hFFFF, 8, -1, -1);
    vectors++;
    if (last_wr() !== {20'd0, 16'h1234} || wr_q.size() !== 1) begin
      miscompares++;
      $display("FAIL pause_wr: got %h n=%0d want %h n=1",
               last_wr(), wr_q.size(), {20'd0, 16'h1234});
    end
    vectors++;
    if (bus.o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_busy: busy %b want 1", bus.o_busy);
    end
    repeat (3) frame(16'hDEAD, 16'hFFFF, -1, -1, -1);
    vectors++;
    if (wr_q.size() !== 1) begin
      miscompares++;
      $display("FAIL paused_quiet: writes %0d want 1", wr_q.size());
    end
    vectors++;
    if (bus.o_address !== 20'd1 || bus.o_sample_cnt !== 21'd1) begin
      miscompares++;
      $display("FAIL paused_hold: addr %0d cnt %0d want 1 1",
               bus.o_address, bus.o_sample_cnt);
    end
    start_pulse();
    frame(16'h0F0F, 16'hFFFF, -1, -1, -1);
    vectors++;
    if (last_wr() !== {20'd1, 16'h0F0F} || wr_q.size() !== 2) begin
      miscompares++;
      $display("FAIL resume_wr: got %h n=%0d want %h n=2",
               last_wr(), wr_q.size(), {20'd1, 16'h0F0F});
    end
    vectors++;
    if (bus.o_sample_cnt !== 21'd2) begin
      miscompares++;
      $display("FAIL resume_cnt: got %0d want 2", bus.o_sample_cnt);
    end
    stop_pulse();
  endtask

  task automatic test_stop();
    wr_q.delete();
    start_pulse();
    frame(16'h1111, 16'hFFFF, -1, -1, -1);
    pulse_busy = 1'b1;
    frame(16'h2222, 16'hFFFF, -1, 5, -1);
    vectors++;
    if (pulse_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_idle: busy %b want 0", pulse_busy);
    end
    vectors++;
    if (wr_q.size() !== 1) begin
      miscompares++;
      $display("FAIL stop_nowrite: writes %0d want 1", wr_q.size());
    end
    vectors++;
    if (bus.o_sample_cnt !== 21'd1 || bus.o_address !== 20'd1) begin
      miscompares++;
      $display("FAIL stop_hold: cnt %0d addr %0d want 1 1",
               bus.o_sample_cnt, bus.o_address);
    end
  endtask

  task automatic test_full();
    logic [35:0] got;
    wr_q.delete();
    start_pulse();
    for (int k = 0; k < 5; k++)
      frame(16'(16'h1000 + k), 16'hFFFF, -1, -1, -1);
    vectors++;
    if (wr_q.size() !== 4) begin
      miscompares++;
      $display("FAIL full_count: writes %0d want 4", wr_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      got = '1;
      if (k < wr_q.size()) got = wr_q[k];
      vectors++;
      if (got !== {20'(k), 16'(16'h1000 + k)}) begin
        miscompares++;
        $display("FAIL full_wr%0d: got %h want %h",
                 k, got, {20'(k), 16'(16'h1000 + k)});
      end
    end
    vectors++;
    if (bus.o_full !== 1'b1 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_flag: full %b busy %b want 1 0",
               bus.o_full, bus.o_busy);
    end
    vectors++;
    if (bus.o_sample_cnt !== 21'd4 || bus.o_address !== 20'd3) begin
      miscompares++;
      $display("FAIL full_hold: cnt %0d addr %0d want 4 3",
               bus.o_sample_cnt, bus.o_address);
    end
    start_pulse();
    idle_step();
    vectors++;
    if (bus.o_full !== 1'b0 || bus.o_address !== 20'd0
        || bus.o_sample_cnt !== 21'd0) begin
      miscompares++;
      $display("FAIL fresh_clear: full %b addr %0d cnt %0d want 0 0 0",
               bus.o_full, bus.o_address, bus.o_sample_cnt);
    end
    frame(16'hBEEF, 16'hFFFF, -1, -1, -1);
    vectors++;
    if (last_wr() !== {20'd0, 16'hBEEF} || wr_q.size() !== 5) begin
      miscompares++;
      $display("FAIL fresh_wr: got %h n=%0d want %h n=5",
               last_wr(), wr_q.size(), {20'd0, 16'hBEEF});
    end
    stop_pulse();
  endtask

  task automatic test_reset_mid();
    wr_q.delete();
    rst_snap = '1;
    start_pulse();
    frame(16'h7777, 16'hFFFF, -1, -1, 6);
    vectors++;
    if (rst_snap !== 60'd0) begin
      miscompares++;
      $display("FAIL rst_async: got %h want 0", rst_snap);
    end
    vectors++;
    if (wr_q.size() !== 0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_nowrite: writes %0d busy %b want 0 0",
               wr_q.size(), bus.o_busy);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_step();
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_stop: busy %b want 0", bus.o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_basic();
    test_pause();
    test_stop();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Consumes the WM8731 ADC stream once the I2C initializer reports done.
- The codec is configured as master, I2S, 16-bit word length.
- This block deserialises the left-channel ADC sample from each LRC frame and emits one 16-bit word per frame with a sequential SRAM write address.
- The SRAM controller sits downstream. A top-level FSM drives start/pause/stop.

Parameters:
- DATA_W, 16, sample width in bits (matches the codec IWL setting).
- ADDR_W, 20, write-address width.
- MAX_ADDR, 2**20-1, last writable address; reaching it ends recording.

Ports:
- i_clk  in  1  codec BCLK; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_init_done  in  1  level from the I2C initializer's o_finished; i_start is ignored while low.
- i_start  in  1  one-cycle pulse: begin recording, or resume from pause.
- i_pause  in  1  one-cycle pulse: pause at the next sample boundary.
- i_stop  in  1  one-cycle pulse: abort and return to idle.
- i_lrc  in  1  codec ADCLRCK; low = left channel.
- i_adcdat  in  1  codec ADCDAT serial data, MSB first.
- o_data  out  DATA_W  captured sample; valid while o_wr_en=1.
- o_address  out  ADDR_W  write address for o_data.
- o_wr_en  out  1  one-cycle write strobe.
- o_sample_cnt  out  ADDR_W+1  number of samples written since the last fresh start.
- o_busy  out  1  high in every state except IDLE.
- o_full  out  1  memory exhausted; sticky until the next fresh start.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All outputs 0; internal shift register 0; bit counter 0.
  - lrc_q=1, so no false edge is seen on the first cycle out of reset.
- LRC edge detection:
  - lrc_q registers i_lrc every cycle.
  - A falling edge is a cycle with lrc_q=1 and i_lrc=0.
- States:
  - IDLE
    - i_start=1 and i_init_done=1 -> WAIT_LRC.
    - On this fresh start: o_address=0, o_sample_cnt=0, o_full=0.
  - WAIT_LRC
    - On a falling LRC edge -> SHIFT, bit counter=0.
    - The edge cycle itself is the I2S one-bit delay slot; i_adcdat is discarded.
  - SHIFT
    - Each cycle: shreg <= {shreg[DATA_W-2:0], i_adcdat}; counter+1.
    - On the cycle the 16th bit is captured -> WRITE.
    - Capture latency: MSB on the 2nd BCLK after the LRC fall, LSB on the 17th.
  - WRITE (exactly one cycle)
    - o_wr_en=1, o_data=shreg, o_address=current address.
    - Next cycle: o_sample_cnt+1.
    - If address==MAX_ADDR -> IDLE with o_full=1.
    - Else address+1, then go to PAUSED if a pause is pending, otherwise WAIT_LRC.
  - PAUSED
    - Address and count are held.
    - i_start -> WAIT_LRC without clearing address or count.
- Right-channel half-frames (LRC high) are ignored: mono recording.
- o_wr_en is 0 in every state other than WRITE.
- Pause:
  - A pulse in WAIT_LRC -> PAUSED next cycle.
  - A pulse in SHIFT or WRITE sets a pending flag; the current sample completes and is written, then -> PAUSED.
  - The flag clears on entering PAUSED.
- Stop:
  - A pulse in any state -> IDLE next cycle.
  - A partially shifted sample is discarded with no write.
  - o_address and o_sample_cnt hold their values so downstream can read the recording length.
  - A stop during WRITE still lets that cycle's strobe happen; the address does not increment.
- Simultaneous pulses: stop > pause > start.
  - i_start is ignored in WAIT_LRC, SHIFT and WRITE.
  - i_pause is ignored in IDLE and PAUSED.
- i_init_done falling mid-recording has no effect: it is only checked on the IDLE start.
- An LRC edge arriving during SHIFT (a malformed frame) is ignored; the counter governs.
- Reset mid-sample: immediate return to IDLE; no strobe is emitted.

Decomposition:
- Shared package aud_pkg:
  - state enum (IDLE, WAIT_LRC, SHIFT, WRITE, PAUSED)
  - DATA_W and ADDR_W defaults
  - the I2S delay-slot constant (1)
- These are shared with the future aud_player.
- Optional sub-module i2s_deser:
  - Contains lrc edge detect, shift register and bit counter.
  - Outputs sample_valid and sample.
  - The recorder FSM wraps it.

Test Plan:
- Fresh start, left=16'hA5C3, right=16'hFFFF, 32 BCLK per half-frame -> one o_wr_en pulse with o_data=16'hA5C3, o_address=0; next frame's write at address 1; o_sample_cnt=1 after the first write.
- Pause pulse mid-SHIFT (bit 8) of a 16'h1234 sample -> 16'h1234 written at the current address, then PAUSED with no further strobes for 3 frames; i_start -> the next write lands at the next sequential address.
- Stop pulse at bit 5 of a sample -> no strobe, IDLE next cycle, o_busy=0, o_sample_cnt unchanged.
- MAX_ADDR=3 build, continuous recording -> writes at addresses 0..3, then IDLE with o_full=1 and no 5th strobe; a fresh i_start clears o_full and rewrites from address 0.
- i_start while i_init_done=0 -> stays IDLE, o_busy=0; same pulse with i_init_done=1 -> WAIT_LRC.
- Async i_rst asserted during SHIFT -> all outputs 0 within the same cycle, no strobe on deassert; i_start+i_stop in the same cycle -> remains IDLE.
